shift_arb_ctrl: RTL and testbench

Two-requester arbiter and sequencer for a shared serial shift chain. It grants one requester at a time using round-robin. It loads the granted parallel word into an internal shift register and drives it MSB-first on `sdo`, while capturing the returning serial stream from `sdi` into a parallel receive word. It sits between parallel producer/consumer logic and the SISO-style shift-register chains on the board side.

---
 rtl/shift_arb_ctrl_if.sv | 31 +++
 rtl/shift_arb_ctrl.sv | 146 ++++++++++++++
 tb/tb_shift_arb_ctrl.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/shift_arb_ctrl_if.sv
// Bus bundle for shift_arb_ctrl: requester handshake, parallel words,
// serial chain pins and receive results. WIDTH must match the attached
// shift_arb_ctrl instance.
interface shift_arb_ctrl_if #(
  parameter int unsigned WIDTH = 8
);
  logic [1:0]       req;
  logic [WIDTH-1:0] data0;
  logic [WIDTH-1:0] data1;
  logic [1:0]       gnt;
  logic             busy;
  logic             sdo;
  logic             sframe;
  logic             sdi;
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;
  logic             rx_id;
  logic             rx_perr;

  // Requester / board side: drives requests, words and the returning stream.
  modport master (
    output req, data0, data1, sdi,
    input  gnt, busy, sdo, sframe, rx_data, rx_valid, rx_id, rx_perr
  );

  // Arbiter / sequencer side.
  modport slave (
    input  req, data0, data1, sdi,
    output gnt, busy, sdo, sframe, rx_data, rx_valid, rx_id, rx_perr
  );
endinterface

// File: rtl/shift_arb_ctrl.sv
// shift_arb_ctrl: two-requester round-robin arbiter feeding a shared serial
// shift chain. The granted word is shifted out MSB-first on sdo while the
// returning sdi stream is captured into rx_data.
// Optional feature macro: SHIFT_ARB_CTRL_PARITY_EN appends an even-parity bit
// to every frame and checks the returned one (rx_perr); without it rx_perr
// is tied low.
module shift_arb_ctrl #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned GAP   = 1
) (
  input  logic           clk,
  input  logic           reset_n,
  shift_arb_ctrl_if.slave bus
);

`ifdef SHIFT_ARB_CTRL_PARITY_EN
  localparam int unsigned FLEN = WIDTH + 1;
`else
  localparam int unsigned FLEN = WIDTH;
`endif
  localparam int unsigned CNT_W    = $clog2(FLEN);
  localparam logic [3:0]  GAP_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_GAP
  } state_t;

  state_t           state;
  logic [FLEN-1:0]  tx_sr;
  logic [FLEN-2:0]  rx_sr;
  logic [CNT_W-1:0] bit_cnt;
  logic [3:0]       gap_cnt;
  logic             owner;
  logic             last;
  logic [WIDTH-1:0] rx_data_r;
  logic             rx_valid_r;
  logic             rx_id_r;

  logic             win;
  logic [1:0]       gnt_c;
  logic [WIDTH-1:0] sel_word;
  logic [FLEN-1:0]  load_frame;
  logic [FLEN-1:0]  rx_full;
  logic [WIDTH-1:0] rx_payload;

  // Round-robin pick: on contention the requester not served last wins.
  always_comb begin
    win   = (bus.req == 2'b11) ? ~last : bus.req[1];
    gnt_c = '0;
    if (reset_n && (state == ST_IDLE) && (bus.req != 2'b00)) begin
      gnt_c[win] = 1'b1;
    end
  end

  // Frame to load on grant and the completed receive word on the last edge.
  always_comb begin
    sel_word = win ? bus.data1 : bus.data0;
`ifdef SHIFT_ARB_CTRL_PARITY_EN
    load_frame = {sel_word, ^sel_word};
`else
    load_frame = sel_word;
`endif
    rx_full    = {rx_sr, bus.sdi};
    rx_payload = rx_full[FLEN-1 -: WIDTH];
  end

`ifdef SHIFT_ARB_CTRL_PARITY_EN
  logic rx_perr_r;
`endif

  // Sequencer FSM with its datapath registers and receive result registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      tx_sr      <= '0;
      rx_sr      <= '0;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      owner      <= 1'b0;
      last       <= 1'b1;
      rx_data_r  <= '0;
      rx_valid_r <= 1'b0;
      rx_id_r    <= 1'b0;
`ifdef SHIFT_ARB_CTRL_PARITY_EN
      rx_perr_r  <= 1'b0;
`endif
    end else begin
      rx_valid_r <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.req != 2'b00) begin
            tx_sr   <= load_frame;
            owner   <= win;
            last    <= win;
            bit_cnt <= CNT_W'(FLEN - 1);
            state   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          tx_sr <= {tx_sr[FLEN-2:0], 1'b0};
          rx_sr <= rx_full[FLEN-2:0];
          if (bit_cnt == '0) begin
            rx_data_r  <= rx_payload;
            rx_id_r    <= owner;
            rx_valid_r <= 1'b1;
`ifdef SHIFT_ARB_CTRL_PARITY_EN
            rx_perr_r  <= rx_full[0] ^ (^rx_payload);
`endif
            if (GAP == 0) begin
              state <= ST_IDLE;
            end else begin
              gap_cnt <= GAP_LOAD;
              state   <= ST_GAP;
            end
          end else begin
            bit_cnt <= bit_cnt - CNT_W'(1);
          end
        end
        ST_GAP: begin
          if (gap_cnt == '0) begin
            state <= ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt - 4'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.gnt      = gnt_c;
  assign bus.busy     = (state != ST_IDLE);
  assign bus.sdo      = (state == ST_SHIFT) & tx_sr[FLEN-1];
  assign bus.sframe   = (state == ST_SHIFT);
  assign bus.rx_data  = rx_data_r;
  assign bus.rx_valid = rx_valid_r;
  assign bus.rx_id    = rx_id_r;
`ifdef SHIFT_ARB_CTRL_PARITY_EN
  assign bus.rx_perr  = rx_perr_r;
`else
  assign bus.rx_perr  = 1'b0;
`endif

endmodule

// File: tb/tb_shift_arb_ctrl.sv
// Testbench for shift_arb_ctrl: scoreboard of expected receive results,
// directed scenarios plus randomized frames, and a GAP=0 instance for
// back-to-back timing.
module tb_shift_arb_ctrl;
  localparam int unsigned W = 8;
  localparam int unsigned G = 1;
`ifdef SHIFT_ARB_CTRL_PARITY_EN
  localparam int unsigned FL = W + 1;
`else
  localparam int unsigned FL = W;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  shift_arb_ctrl_if #(.WIDTH(W)) bif ();
  shift_arb_ctrl_if #(.WIDTH(W)) bz ();

  shift_arb_ctrl #(.WIDTH(W), .GAP(G)) u_dut (
    .clk(clk), .reset_n(reset_n), .bus(bif)
  );
  shift_arb_ctrl #(.WIDTH(W), .GAP(0)) u_dut_z (
    .clk(clk), .reset_n(reset_n), .bus(bz)
  );

  typedef struct packed {
    logic         id;
    logic [W-1:0] data;
    logic         perr;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  logic last_srv = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame as it should appear on the wire: payload MSB-first, then parity.
  function automatic logic [FL-1:0] frame_of(input logic [W-1:0] d);
`ifdef SHIFT_ARB_CTRL_PARITY_EN
    return {d, ^d};
`else
    return d;
`endif
  endfunction

  // Requester served next: a lone request wins; on contention the other one.
  function automatic logic pick(input logic [1:0] r);
    if (r == 2'b01) return 1'b0;
    if (r == 2'b10) return 1'b1;
    return (last_srv == 1'b0) ? 1'b1 : 1'b0;
  endfunction

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge clk);
      bif.req = 2'b00;
      #1;
      chk("idle_gnt", 32'(bif.gnt), 32'd0);
      chk("idle_busy", 32'(bif.busy), 32'd0);
      chk("idle_sframe", 32'(bif.sframe), 32'd0);
    end
  endtask

  // One complete frame: grant cycle, FL bit cycles, then the gap cycles.
  task automatic run_frame(input logic [1:0] r, input logic [W-1:0] d0, input logic [W-1:0] d1,
                           input bit loop, input logic [FL-1:0] s_ind, input bit flip, input bit hold);
    logic          win;
    logic [FL-1:0] tx;
    logic [FL-1:0] s;
    exp_t          e;
    @(negedge clk);
    bif.req   = r;
    bif.data0 = d0;
    bif.data1 = d1;
    bif.sdi   = 1'b0;
    win = pick(r);
    #1;
    chk("gnt", 32'(bif.gnt), win ? 32'd2 : 32'd1);
    last_srv = win;
    tx = frame_of(win ? d1 : d0);
    s  = loop ? tx : s_ind;
`ifdef SHIFT_ARB_CTRL_PARITY_EN
    if (flip) s[0] = ~s[0];
`else
    if (flip) s = s;
`endif
    for (int unsigned k = 0; k < FL; k++) begin
      @(negedge clk);
      if (!hold) bif.req = 2'b00;
      bif.sdi = s[FL-1-k];
      #1;
      chk("sdo", 32'(bif.sdo), 32'(tx[FL-1-k]));
      chk("sframe", 32'(bif.sframe), 32'd1);
      chk("busy", 32'(bif.busy), 32'd1);
      chk("gnt_shift", 32'(bif.gnt), 32'd0);
    end
    e.id   = win;
    e.data = s[FL-1 -: W];
`ifdef SHIFT_ARB_CTRL_PARITY_EN
    e.perr = s[0] ^ (^e.data);
`else
    e.perr = 1'b0;
`endif
    sb_q.push_back(e);
    for (int unsigned g = 0; g < G; g++) begin
      @(negedge clk);
      #1;
      chk("gap_sdo", 32'(bif.sdo), 32'd0);
      chk("gap_sframe", 32'(bif.sframe), 32'd0);
      chk("gap_busy", 32'(bif.busy), 32'd1);
      chk("gap_gnt", 32'(bif.gnt), 32'd0);
    end
  endtask

  // Monitor: every rx_valid pulse must match the oldest expected frame.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (bif.rx_valid === 1'b1) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rx_unexpected: got rx_valid=1 expected no frame at %0t", $time);
        end else begin
          e = sb_q.pop_front();
          chk("rx_data", 32'(bif.rx_data), 32'(e.data));
          chk("rx_id", 32'(bif.rx_id), 32'(e.id));
          chk("rx_perr", 32'(bif.rx_perr), 32'(e.perr));
        end
      end
    end
  end

  initial begin : stim
    logic [31:0]   rnd;
    logic [FL-1:0] s;
    logic [W-1:0]  d;
    logic [FL-1:0] tz;
    logic [1:0]    r;
    bit            hold;
    bif.req = 2'b00; bif.data0 = '0; bif.data1 = '0; bif.sdi = 1'b0;
    bz.req  = 2'b00; bz.data0  = '0; bz.data1  = '0; bz.sdi  = 1'b0;

    // Reset state, with requests present to show gnt is forced low.
    repeat (2) @(negedge clk);
    bif.req = 2'b11;
    #1;
    chk("rst_gnt", 32'(bif.gnt), 32'd0);
    chk("rst_busy", 32'(bif.busy), 32'd0);
    chk("rst_sdo", 32'(bif.sdo), 32'd0);
    chk("rst_sframe", 32'(bif.sframe), 32'd0);
    chk("rst_rx_valid", 32'(bif.rx_valid), 32'd0);
    chk("rst_rx_data", 32'(bif.rx_data), 32'd0);
    chk("rst_rx_id", 32'(bif.rx_id), 32'd0);
    chk("rst_rx_perr", 32'(bif.rx_perr), 32'd0);
    @(negedge clk);
    bif.req = 2'b00;
    reset_n = 1'b1;

    // Single request A5 in loopback, then contention held for four frames.
    run_frame(2'b01, 8'hA5, 8'h00, 1'b1, '0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) run_frame(2'b11, 8'h11, 8'h22, 1'b1, '0, 1'b0, 1'b1);
    idle(2);

    // Independent sdi: transmit FF, return 3C.
    s = '0;
    s[FL-1 -: W] = 8'h3C;
    run_frame(2'b01, 8'hFF, 8'h00, 1'b0, s, 1'b0, 1'b0);
    // Parity frame 07 in loopback, then with the returned parity bit inverted.
    run_frame(2'b01, 8'h07, 8'h00, 1'b1, '0, 1'b0, 1'b0);
    run_frame(2'b10, 8'h00, 8'h07, 1'b1, '0, 1'b1, 1'b0);
    idle(1);

    // Reset during bit 4 of a frame.
    @(negedge clk);
    bif.req = 2'b11; bif.data0 = 8'h5A; bif.data1 = 8'hC3;
    r = pick(2'b11);
    #1;
    chk("abort_gnt", 32'(bif.gnt), r ? 32'd2 : 32'd1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bif.req = 2'b00;
      bif.sdi = 1'b1;
    end
    @(negedge clk);
    bif.req = 2'b11;
    reset_n = 1'b0;
    #1;
    chk("abort_sdo", 32'(bif.sdo), 32'd0);
    chk("abort_sframe", 32'(bif.sframe), 32'd0);
    chk("abort_busy", 32'(bif.busy), 32'd0);
    chk("abort_rx_valid", 32'(bif.rx_valid), 32'd0);
    chk("abort_gnt_rst", 32'(bif.gnt), 32'd0);
    last_srv = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("abort_rx_data", 32'(bif.rx_data), 32'd0);
    @(negedge clk);
    bif.req = 2'b00;
    reset_n = 1'b1;
    run_frame(2'b11, 8'h3A, 8'hB7, 1'b1, '0, 1'b0, 1'b1);
    run_frame(2'b11, 8'h3A, 8'hB7, 1'b1, '0, 1'b0, 1'b0);

    // Randomized frames.
    for (int i = 0; i < 40; i++) begin
      r    = 2'($urandom_range(1, 3));
      hold = 1'($urandom_range(0, 1));
      rnd  = $urandom;
      s    = rnd[FL-1:0];
      run_frame(r, 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), s,
                1'($urandom_range(0, 1)), hold);
      if (!hold) idle($urandom_range(0, 2));
    end
    idle(1);

    // GAP=0 instance: back-to-back frames from requester 1 in loopback.
    d  = 8'($urandom);
    tz = frame_of(d);
    @(negedge clk);
    bz.req = 2'b10;
    bz.data1 = d;
    #1;
    chk("z_gnt_first", 32'(bz.gnt), 32'd2);
    for (int f = 0; f < 3; f++) begin
      for (int unsigned k = 0; k < FL; k++) begin
        @(negedge clk);
        bz.sdi = tz[FL-1-k];
        #1;
        chk("z_sdo", 32'(bz.sdo), 32'(tz[FL-1-k]));
        chk("z_busy", 32'(bz.busy), 32'd1);
      end
      @(negedge clk);
      if (f == 2) bz.req = 2'b00;
      #1;
      chk("z_rx_valid", 32'(bz.rx_valid), 32'd1);
      chk("z_rx_data", 32'(bz.rx_data), 32'(d));
      chk("z_rx_id", 32'(bz.rx_id), 32'd1);
      chk("z_rx_perr", 32'(bz.rx_perr), 32'd0);
      chk("z_gnt", 32'(bz.gnt), (f == 2) ? 32'd0 : 32'd2);
    end

    idle(3);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
